dpcm_rle: RTL and testbench

- Downstream consumer of the DPCM residual stage.
- Takes a byte stream of 8-bit absolute residuals and run-length encodes it into (count, value) tokens for the packer/storage stage.
- Compresses the long zero/constant-residual runs that DPCM produces on smooth image regions.
- Valid/ready handshake on both sides; registered output; one token per cycle maximum.

---
 rtl/dpcm_rle.sv | 173 +++++++++++++++++
 tb/tb_dpcm_rle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpcm_rle.sv
// dpcm_rle: run-length encoder turning 8-bit residual bytes into (count, value) tokens.
// Optional statistics counters are enabled with `define DPCM_RLE_STATS_EN.
module dpcm_rle #(
   parameter int CNT_W   = 8,
   parameter int MAX_RUN = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [7:0]       out_value,
   output logic             out_last
`ifdef DPCM_RLE_STATS_EN
   ,
   output logic [15:0]      stat_bytes,
   output logic [15:0]      stat_tokens
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state;
   state_t           state_nx;
   logic [7:0]       run_val;
   logic [7:0]       val_nx;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             out_free;
   logic             accept;
   logic             same;
   logic             emit;
   logic [CNT_W-1:0] emit_cnt;
   logic [7:0]       emit_val;
   logic             emit_last;

   // Output slot can take a new token when empty or draining this edge.
   assign out_free = !out_valid || out_ready;
   assign in_ready = rst_n && (state != FLUSH) && out_free;
   assign accept   = in_valid && in_ready;
   assign same     = (in_data == run_val) && (run_cnt < MAX_C);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept && !in_last) state_nx = RUN;
         end
         RUN: begin
            if (accept) begin
               if (same) begin
                  if (in_last) state_nx = IDLE;
               end else if (in_last) begin
                  state_nx = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (out_free) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Token emission and next run contents.
   always_comb begin
      emit      = 1'b0;
      emit_cnt  = run_cnt;
      emit_val  = run_val;
      emit_last = 1'b0;
      val_nx    = run_val;
      cnt_nx    = run_cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               val_nx = in_data;
               cnt_nx = ONE;
               if (in_last) begin
                  emit      = 1'b1;
                  emit_cnt  = ONE;
                  emit_val  = in_data;
                  emit_last = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (same) begin
                  cnt_nx = run_cnt + ONE;
                  if (in_last) begin
                     emit      = 1'b1;
                     emit_cnt  = run_cnt + ONE;
                     emit_val  = in_data;
                     emit_last = 1'b1;
                  end
               end else begin
                  emit   = 1'b1;
                  val_nx = in_data;
                  cnt_nx = ONE;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               emit      = 1'b1;
               emit_last = 1'b1;
               cnt_nx    = '0;
            end
         end
         default: begin
            emit = 1'b0;
         end
      endcase
   end

   // Open-run registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_val <= '0;
         run_cnt <= '0;
      end else begin
         run_val <= val_nx;
         run_cnt <= cnt_nx;
      end
   end

   // Output token register; held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_count <= '0;
         out_value <= '0;
         out_last  <= 1'b0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_count <= emit_cnt;
         out_value <= emit_val;
         out_last  <= emit_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DPCM_RLE_STATS_EN
   // Saturating beat and token counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_bytes  <= '0;
         stat_tokens <= '0;
      end else begin
         if (accept && stat_bytes != 16'hFFFF)
            stat_bytes <= stat_bytes + 16'd1;
         if (out_valid && out_ready && stat_tokens != 16'hFFFF)
            stat_tokens <= stat_tokens + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dpcm_rle.sv
// tb_dpcm_rle: randomized bench for dpcm_rle against a run-splitting model.
// Checks token order, stall stability, latency, reset and saturation.
module tb_dpcm_rle;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_count;
   logic [7:0]  out_value;
   logic        out_last;
`ifdef DPCM_RLE_STATS_EN
   logic [15:0] stat_bytes;
   logic [15:0] stat_tokens;
`endif

   int tests;
   int fails;

   logic [7:0]  src[$];
   logic [16:0] exp_q[$];

   dpcm_rle #(.CNT_W(8), .MAX_RUN(255)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_count(out_count),
      .out_value(out_value),
      .out_last(out_last)
`ifdef DPCM_RLE_STATS_EN
      ,
      .stat_bytes(stat_bytes),
      .stat_tokens(stat_tokens)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference: maximal equal-value runs, split every 255 bytes,
   // last token of the frame flagged.
   task automatic build_expect();
      int i;
      int n;
      int c;
      logic [7:0] v;
      exp_q.delete();
      n = src.size();
      i = 0;
      while (i < n) begin
         v = src[i];
         c = 0;
         while (i < n && src[i] == v && c < 255) begin
            c++;
            i++;
         end
         exp_q.push_back({8'(c), v, (i == n)});
      end
   endtask

   task automatic run_frame(input int vpct, input int rpct, input int hold,
                            output int lowcnt, output int lat);
      int idx;
      int cyc;
      int acc_cyc;
      logic held;
      logic [16:0] saved;
      logic [16:0] tok;
      build_expect();
      idx = 0;
      cyc = 0;
      acc_cyc = -1;
      lat = -1;
      lowcnt = 0;
      held = 1'b0;
      saved = '0;
      while ((idx < src.size() || exp_q.size() > 0) && cyc < 20000) begin
         @(posedge clk);
         #1;
         in_valid  = (idx < src.size()) && ($urandom_range(1, 100) <= vpct);
         in_data   = (idx < src.size()) ? src[idx] : 8'h00;
         in_last   = (idx == src.size() - 1);
         out_ready = (cyc >= hold) && ($urandom_range(1, 100) <= rpct);
         @(negedge clk);
         if (!in_ready) lowcnt++;
         tok = {out_count, out_value, out_last};
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_token", 32'(tok), 32'(saved));
         end
         held  = out_valid && !out_ready;
         saved = tok;
         if (out_valid && out_last && lat < 0 && acc_cyc >= 0)
            lat = cyc - acc_cyc;
         if (in_valid && in_ready) begin
            idx++;
            if (idx == src.size()) acc_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_token", 32'(tok), 32'h1FFFF);
            else chk("token", 32'(tok), 32'(exp_q.pop_front()));
         end
         cyc++;
      end
      if (cyc >= 20000) chk("timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int low;
      int lat;
      int nruns;
      int rl;
      logic [7:0] v;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      in_last = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_token", 32'({out_count, out_value, out_last}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // 0,0,0,5 last: two tokens, one FLUSH cycle with in_ready low.
      src = '{8'd0, 8'd0, 8'd0, 8'd5};
      run_frame(100, 100, 0, low, lat);
      chk("flush_low_cycles", 32'(low), 32'd1);
`ifdef DPCM_RLE_STATS_EN
      chk("stat_bytes", 32'(stat_bytes), 32'd4);
      chk("stat_tokens", 32'(stat_tokens), 32'd2);
`endif

      // 300 zeros: 255 then 45.
      src.delete();
      repeat (300) src.push_back(8'h00);
      run_frame(100, 100, 0, low, lat);

      // 256 equal bytes: saturation split 255 then 1.
      src.delete();
      repeat (256) src.push_back(8'hA5);
      run_frame(100, 100, 0, low, lat);

      // Single byte with last: one-cycle latency.
      src = '{8'h7F};
      run_frame(100, 100, 0, low, lat);
      chk("single_latency", 32'(lat), 32'd1);

      // Distinct bytes with downstream stalled for 5 cycles.
      src = '{8'd1, 8'd2, 8'd3, 8'd4};
      run_frame(100, 100, 5, low, lat);
      chk("stall_in_ready_low", 32'(low >= 4), 32'd1);

      // Reset in the middle of an open run of 7.
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h00;
      in_last = 1'b0;
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst_hold_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst_rel_ready", 32'(in_ready), 32'd1);
      src = '{8'h09};
      run_frame(100, 100, 0, low, lat);

      // Random frames with run-rich content and random handshakes.
      for (int f = 0; f < 30; f++) begin
         src.delete();
         nruns = $urandom_range(1, 6);
         for (int r = 0; r < nruns; r++) begin
            v = 8'($urandom_range(0, 3));
            if ($urandom_range(1, 10) == 1) rl = $urandom_range(200, 300);
            else rl = $urandom_range(1, 8);
            repeat (rl) src.push_back(v);
         end
         run_frame($urandom_range(40, 100), $urandom_range(30, 100),
                   $urandom_range(0, 4), low, lat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
